// File: rtl/calc_sequencer.sv
// Purpose: steps the user through operand A, operand B and opcode entry, feeds the ALU from registers, holds the result.
// Latency: result and result_valid appear one cycle after the opcode is entered (S_EXEC -> S_RES).
// Backpressure: none; enter/undo are single-cycle pulses, and pulses arriving during S_EXEC are dropped.
module calc_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enter,
  input  logic             undo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [2:0]       alu_error,
  output logic [WIDTH-1:0] display,
  output logic [3:0]       state_leds,
  output logic [2:0]       rgb,
  output logic             result_valid
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_RES  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, op_reg, res_reg;
  logic             ld_a, ld_b, ld_op, ld_res, clr_res;

  // State register; reset discards any partially entered operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_A;
    else       state <= state_nxt;
  end

  // Next-state and register load strobes; enter always wins over undo.
  always_comb begin
    state_nxt = state;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_op     = 1'b0;
    ld_res    = 1'b0;
    clr_res   = 1'b0;
    case (state)
      S_A: begin
        if (enter) begin
          ld_a      = 1'b1;
          state_nxt = S_B;
        end
      end
      S_B: begin
        if (enter) begin
          ld_b      = 1'b1;
          state_nxt = S_OP;
        end else if (undo) begin
          state_nxt = S_A;
        end
      end
      S_OP: begin
        if (enter) begin
          ld_op     = 1'b1;
          state_nxt = S_EXEC;
        end else if (undo) begin
          state_nxt = S_B;
        end
      end
      S_EXEC: begin
        ld_res    = 1'b1;
        state_nxt = S_RES;
      end
      S_RES: begin
        if (enter) begin
          clr_res   = 1'b1;
          state_nxt = S_A;
        end else if (undo) begin
          clr_res   = 1'b1;
          state_nxt = S_OP;
        end
      end
      default: state_nxt = S_A;
    endcase
  end

  // Operand and opcode registers; only the 2-bit opcode field is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= '0;
    end else begin
      if (ld_a)  a_reg  <= data_in;
      if (ld_b)  b_reg  <= data_in;
      if (ld_op) op_reg <= {{(WIDTH-2){1'b0}}, data_in[1:0]};
    end
  end

  // Result capture; the error code is only meaningful for add, so it is masked otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_reg      <= '0;
      rgb          <= 3'b000;
      result_valid <= 1'b0;
    end else if (ld_res) begin
      res_reg      <= alu_result;
      rgb          <= (op_reg == '0) ? alu_error : 3'b000;
      result_valid <= 1'b1;
    end else if (clr_res) begin
      rgb          <= 3'b000;
      result_valid <= 1'b0;
    end
  end

  assign alu_a  = a_reg;
  assign alu_b  = b_reg;
  assign alu_op = op_reg;

  // Display shows the live switch word while entering, the captured result afterwards.
  always_comb begin
    display    = data_in;
    state_leds = 4'b0001;
    case (state)
      S_A:     begin display = data_in; state_leds = 4'b0001; end
      S_B:     begin display = data_in; state_leds = 4'b0010; end
      S_OP:    begin display = data_in; state_leds = 4'b0100; end
      S_EXEC:  begin display = res_reg; state_leds = 4'b1000; end
      S_RES:   begin display = res_reg; state_leds = 4'b1000; end
      default: begin display = data_in; state_leds = 4'b0001; end
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Purpose: directed checks of calc_sequencer entry flow with a behavioural 16-bit ALU alongside.
// Latency: checks are taken on the falling edge after each driven rising edge.
// Backpressure: not applicable; stimulus is pulse driven.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        enter, undo;
  logic [15:0] alu_a, alu_b, alu_op, alu_result, display;
  logic [2:0]  alu_error, rgb;
  logic [3:0]  state_leds;
  logic        result_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .enter(enter), .undo(undo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_error(alu_error),
    .display(display), .state_leds(state_leds), .rgb(rgb), .result_valid(result_valid)
  );

  // Behavioural ALU: add/sub/and/or, error 1 on signed add overflow, 2 on signed sub overflow.
  always_comb begin
    alu_error = 3'd0;
    case (alu_op[1:0])
      2'd0: begin
        alu_result = alu_a + alu_b;
        if (alu_a[15] == alu_b[15] && alu_result[15] != alu_a[15]) alu_error = 3'd1;
      end
      2'd1: begin
        alu_result = alu_a - alu_b;
        if (alu_a[15] != alu_b[15] && alu_result[15] != alu_a[15]) alu_error = 3'd2;
      end
      2'd2:    alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs from a falling edge, return on the next falling edge.
  task automatic step(input logic [15:0] d, input logic e, input logic u);
    data_in = d;
    enter   = e;
    undo    = u;
    @(posedge clk);
    @(negedge clk);
    enter = 1'b0;
    undo  = 1'b0;
  endtask

  // Enter A, B and opcode, then idle through S_EXEC into S_RES.
  task automatic run_calc(input logic [15:0] a, input logic [15:0] b, input logic [15:0] op);
    step(a, 1'b1, 1'b0);
    step(b, 1'b1, 1'b0);
    step(op, 1'b1, 1'b0);
    step(16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; data_in = 16'h1234; enter = 1'b0; undo = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_leds",  state_leds,   4'b0001);
    check("rst_valid", result_valid, 1'b0);
    check("rst_rgb",   rgb,          3'b000);
    check("rst_alu_a", alu_a,        16'h0000);
    check("rst_alu_b", alu_b,        16'h0000);
    check("rst_alu_op", alu_op,      16'h0000);
    check("rst_disp",  display,      16'h1234);
    reset = 1'b0;
    @(negedge clk);

    // 1: add overflow, latency of result_valid
    step(16'h7000, 1'b1, 1'b0);
    check("t1_leds_b", state_leds, 4'b0010);
    check("t1_alu_a",  alu_a,      16'h7000);
    step(16'h7000, 1'b1, 1'b0);
    check("t1_leds_op", state_leds, 4'b0100);
    check("t1_preview", display,    16'h7000);
    step(16'h0000, 1'b1, 1'b0);
    check("t1_exec_leds",  state_leds,   4'b1000);
    check("t1_exec_valid", result_valid, 1'b0);
    step(16'h0000, 1'b0, 1'b0);
    check("t1_valid", result_valid, 1'b1);
    check("t1_disp",  display,      16'hE000);
    check("t1_rgb",   rgb,          3'b001);
    step(16'h5555, 1'b0, 1'b0);
    check("t1_hold_disp", display, 16'hE000);

    // 2: subtraction, then enter returns to S_A
    step(16'h0000, 1'b1, 1'b0);
    check("t2_leds_a", state_leds,   4'b0001);
    check("t2_valid0", result_valid, 1'b0);
    check("t2_rgb0",   rgb,          3'b000);
    run_calc(16'h0005, 16'h0003, 16'h0001);
    check("t2_disp", display, 16'h0002);
    check("t2_rgb",  rgb,     3'b000);
    step(16'h0000, 1'b1, 1'b0);
    check("t2_back_leds",  state_leds,   4'b0001);
    check("t2_back_valid", result_valid, 1'b0);

    // sub overflow: ALU flags an error but rgb only reports add errors
    run_calc(16'h8000, 16'h0001, 16'h0001);
    check("sub_ovf_disp", display, 16'h7FFF);
    check("sub_ovf_rgb",  rgb,     3'b000);
    step(16'h0000, 1'b1, 1'b0);

    // 3: AND, undo to re-enter opcode as OR (only [1:0] latched)
    run_calc(16'h00F0, 16'h003C, 16'hFFF2);
    check("t3_op_trunc", alu_op,  16'h0002);
    check("t3_and",      display, 16'h0030);
    step(16'h0000, 1'b0, 1'b1);
    check("t3_undo_leds",  state_leds,   4'b0100);
    check("t3_undo_valid", result_valid, 1'b0);
    step(16'h0003, 1'b1, 1'b0);
    step(16'h0000, 1'b0, 1'b0);
    check("t3_or",    display, 16'h00FC);
    check("t3_alu_a", alu_a,   16'h00F0);
    check("t3_alu_b", alu_b,   16'h003C);
    check("t3_alu_op", alu_op, 16'h0003);
    step(16'h0000, 1'b1, 1'b0);

    // 4: undo chain S_OP -> S_B -> S_A, undo in S_A is a no-op
    step(16'h1111, 1'b1, 1'b0);
    step(16'h2222, 1'b1, 1'b0);
    check("t4_leds_op", state_leds, 4'b0100);
    step(16'h0000, 1'b0, 1'b1);
    check("t4_leds_b", state_leds, 4'b0010);
    step(16'h0000, 1'b0, 1'b1);
    check("t4_leds_a", state_leds, 4'b0001);
    check("t4_a_kept", alu_a,      16'h1111);
    step(16'hABCD, 1'b0, 1'b1);
    check("t4_undo_a",  state_leds, 4'b0001);
    check("t4_preview", display,    16'hABCD);

    // 6: enter+undo together in S_B, pulses during S_EXEC dropped
    step(16'h0042, 1'b1, 1'b0);
    step(16'h0013, 1'b1, 1'b1);
    check("t6_leds_op", state_leds, 4'b0100);
    check("t6_alu_b",   alu_b,      16'h0013);
    step(16'h0003, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b1);
    check("t6_res_leds", state_leds,   4'b1000);
    check("t6_valid",    result_valid, 1'b1);
    check("t6_disp",     display,      16'h0053);
    step(16'h0000, 1'b0, 1'b0);
    check("t6_stay_res", state_leds, 4'b1000);

    // 5: asynchronous reset mid-cycle while in S_B
    step(16'h0000, 1'b1, 1'b0);
    step(16'h0777, 1'b1, 1'b0);
    check("t5_pre_leds", state_leds, 4'b0010);
    #2 reset = 1'b1;
    #1;
    check("t5_leds",   state_leds,   4'b0001);
    check("t5_alu_a",  alu_a,        16'h0000);
    check("t5_alu_op", alu_op,       16'h0000);
    check("t5_valid",  result_valid, 1'b0);
    check("t5_rgb",    rgb,          3'b000);
    @(negedge clk);
    reset = 1'b0;
    step(16'h0009, 1'b1, 1'b0);
    check("t5_after_leds", state_leds, 4'b0010);
    check("t5_after_a",    alu_a,      16'h0009);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
